// File: rtl/gpio_readback.sv
// gpio_readback: host-facing readback transmitter.
// On an enable rise the block snapshots N_WORDS status words and their XOR
// checksum, then steps one word per host tick onto GPIO_OUT, ending on the
// checksum. Dropping enable aborts from any state.
module gpio_readback #(
  parameter int GPIO_WIDTH = 32,
  parameter int N_WORDS    = 16,
  parameter int LED_WIDTH  = 8
) (
  input  logic                          ADC_CLK,
  input  logic                          RST,
  input  logic [GPIO_WIDTH-1:0]         GPIO_0,
  input  logic [N_WORDS*GPIO_WIDTH-1:0] stat_flat,
  output logic [GPIO_WIDTH-1:0]         GPIO_OUT,
  output logic                          busy,
  output logic                          done,
  output logic [LED_WIDTH-1:0]          LED_OUT
);

  localparam int         IW   = $clog2(N_WORDS);
  localparam logic [4:0] LAST = 5'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                                state;
  logic [4:0]                            idx;
  logic [4:0]                            nxt;
  logic [N_WORDS-1:0][GPIO_WIDTH-1:0]    shadow;
  logic [GPIO_WIDTH-1:0]                 csum;
  logic [GPIO_WIDTH-1:0]                 csum_in;

  logic [1:0] en_sync, tk_sync;
  logic       en_d, tk_d;
  logic       en_s, tk_s;
  logic       en_rise, en_low, tk_rise;

  // Two-flop synchronisers for the asynchronous host bits, plus a delay flop
  // each for edge detection. en_d resets low so a held enable re-fires after reset.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      en_sync <= '0;
      tk_sync <= '0;
      en_d    <= 1'b0;
      tk_d    <= 1'b0;
    end else begin
      en_sync <= {en_sync[0], GPIO_0[GPIO_WIDTH-1]};
      tk_sync <= {tk_sync[0], GPIO_0[GPIO_WIDTH-2]};
      en_d    <= en_sync[1];
      tk_d    <= tk_sync[1];
    end
  end

  assign en_s    = en_sync[1];
  assign tk_s    = tk_sync[1];
  assign en_rise = en_s & ~en_d;
  assign en_low  = ~en_s;
  assign tk_rise = tk_s & ~tk_d;
  assign nxt     = idx + 5'd1;

  // Checksum of the live inputs, latched together with the snapshot.
  always_comb begin
    csum_in = '0;
    for (int i = 0; i < N_WORDS; i++)
      csum_in ^= stat_flat[i*GPIO_WIDTH +: GPIO_WIDTH];
  end

  // Readback FSM: enable-low abort wins everywhere; otherwise snapshot in
  // IDLE, step per tick in SEND, park on the checksum in DONE.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      GPIO_OUT <= '0;
      shadow   <= '0;
      csum     <= '0;
    end else if (en_low) begin
      state    <= IDLE;
      idx      <= '0;
      GPIO_OUT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_rise) begin
            shadow   <= stat_flat;
            csum     <= csum_in;
            GPIO_OUT <= stat_flat[GPIO_WIDTH-1:0];
            idx      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tk_rise) begin
            if (idx == LAST) begin
              GPIO_OUT <= csum;
              state    <= DONE;
            end else begin
              idx      <= nxt;
              GPIO_OUT <= shadow[nxt[IW-1:0]];
            end
          end
        end
        DONE: ;
        default: begin
          state    <= IDLE;
          idx      <= '0;
          GPIO_OUT <= '0;
        end
      endcase
    end
  end

  assign busy    = (state == SEND);
  assign done    = (state == DONE);
  assign LED_OUT = LED_WIDTH'({state, 1'b0, idx});

endmodule

// File: tb/tb_gpio_readback.sv
// Directed bench for gpio_readback: reset, ignored ticks, full readback,
// snapshot isolation, abort/restart, DONE tick immunity, async reset mid-SEND.
module tb_gpio_readback;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int LW = 8;
  localparam int EN = W - 1;
  localparam int TK = W - 2;

  logic            ADC_CLK = 1'b0;
  logic            RST;
  logic [W-1:0]    GPIO_0;
  logic [N*W-1:0]  stat_flat;
  logic [W-1:0]    GPIO_OUT;
  logic            busy, done;
  logic [LW-1:0]   LED_OUT;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_readback #(.GPIO_WIDTH(W), .N_WORDS(N), .LED_WIDTH(LW)) dut (
    .ADC_CLK  (ADC_CLK),
    .RST      (RST),
    .GPIO_0   (GPIO_0),
    .stat_flat(stat_flat),
    .GPIO_OUT (GPIO_OUT),
    .busy     (busy),
    .done     (done),
    .LED_OUT  (LED_OUT)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the falling edge for sampling/driving.
  task automatic cyc(input int n);
    repeat (n) @(posedge ADC_CLK);
    @(negedge ADC_CLK);
  endtask

  // One host tick: high 4 cycles, check the presented word, low 4 cycles.
  task automatic tick(input string tag, input logic [31:0] exp);
    GPIO_0[TK] = 1'b1;
    cyc(4);
    chk(tag, GPIO_OUT, exp);
    GPIO_0[TK] = 1'b0;
    cyc(4);
  endtask

  logic [31:0] w;

  initial begin
    RST       = 1'b1;
    GPIO_0    = '0;
    stat_flat = '0;
    cyc(3);
    chk("rst_out",  GPIO_OUT, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_led",  {24'b0, LED_OUT}, 32'h0);
    RST = 1'b0;
    cyc(2);

    // Ticks with enable low do nothing.
    tick("idle_tick0", 32'h0);
    tick("idle_tick1", 32'h0);
    chk("idle_led", {24'b0, LED_OUT}, 32'h0);

    // Basic readback: word i = A0000000+i, checksum 0.
    for (int i = 0; i < N; i++) stat_flat[i*W +: W] = 32'hA000_0000 + i;
    GPIO_0[EN] = 1'b1;
    cyc(4);
    chk("basic_w0",   GPIO_OUT, 32'hA000_0000);
    chk("basic_busy", {31'b0, busy}, 32'h1);
    chk("basic_led0", {24'b0, LED_OUT}, 32'h40);
    for (int t = 1; t < N; t++) tick("basic_word", 32'hA000_0000 + t);
    chk("basic_led15", {24'b0, LED_OUT}, 32'h4F);
    tick("basic_csum", 32'h0);
    chk("basic_done", {31'b0, done}, 32'h1);
    chk("basic_nbusy", {31'b0, busy}, 32'h0);
    chk("basic_led", {24'b0, LED_OUT}, 32'h8F);

    GPIO_0[EN] = 1'b0;
    cyc(4);
    chk("off_out",  GPIO_OUT, 32'h0);
    chk("off_done", {31'b0, done}, 32'h0);
    chk("off_led",  {24'b0, LED_OUT}, 32'h0);

    // Snapshot isolation: inputs go to all-ones right after the snapshot.
    // Words 0..14 = 5A5A0000+i, word 15 = 00001234 -> csum 5A5A123B.
    for (int i = 0; i < N - 1; i++) stat_flat[i*W +: W] = 32'h5A5A_0000 + i;
    stat_flat[(N-1)*W +: W] = 32'h0000_1234;
    GPIO_0[EN] = 1'b1;
    cyc(4);
    chk("iso_w0", GPIO_OUT, 32'h5A5A_0000);
    stat_flat = '1;
    for (int t = 1; t < N; t++) begin
      w = (t == N - 1) ? 32'h0000_1234 : 32'h5A5A_0000 + t;
      tick("iso_word", w);
    end
    tick("iso_csum", 32'h5A5A_123B);
    // Extra ticks in DONE are ignored.
    for (int t = 0; t < 3; t++) tick("done_hold", 32'h5A5A_123B);
    chk("done_led", {24'b0, LED_OUT}, 32'h8F);

    GPIO_0[EN] = 1'b0;
    cyc(4);

    // Abort after 5 ticks, then restart.
    for (int i = 0; i < N; i++) stat_flat[i*W +: W] = 32'h0000_1000 + i;
    GPIO_0[EN] = 1'b1;
    cyc(4);
    chk("ab_w0", GPIO_OUT, 32'h0000_1000);
    for (int t = 1; t <= 5; t++) tick("ab_word", 32'h0000_1000 + t);
    GPIO_0[EN] = 1'b0;
    cyc(2);
    chk("ab_latency", GPIO_OUT, 32'h0000_1005);
    cyc(1);
    chk("ab_out", GPIO_OUT, 32'h0);
    chk("ab_led", {24'b0, LED_OUT}, 32'h0);
    chk("ab_busy", {31'b0, busy}, 32'h0);
    cyc(2);
    GPIO_0[EN] = 1'b1;
    cyc(4);
    chk("ab_re_w0",  GPIO_OUT, 32'h0000_1000);
    chk("ab_re_led", {24'b0, LED_OUT}, 32'h40);

    // Async reset at idx 7, then restart with enable held high.
    for (int t = 1; t <= 7; t++) tick("ar_word", 32'h0000_1000 + t);
    chk("ar_led7", {24'b0, LED_OUT}, 32'h47);
    for (int i = 0; i < N; i++) stat_flat[i*W +: W] = 32'h2000_0000 + i;
    RST = 1'b1;
    #1;
    chk("ar_out",  GPIO_OUT, 32'h0);
    chk("ar_busy", {31'b0, busy}, 32'h0);
    chk("ar_done", {31'b0, done}, 32'h0);
    chk("ar_led",  {24'b0, LED_OUT}, 32'h0);
    @(negedge ADC_CLK);
    RST = 1'b0;
    cyc(1);
    chk("ar_wait", {31'b0, busy}, 32'h0);
    cyc(2);
    chk("ar_w0",   GPIO_OUT, 32'h2000_0000);
    chk("ar_sbusy", {31'b0, busy}, 32'h1);
    tick("ar_w1", 32'h2000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
